// File: rtl/ntt_bank_addr_gen.sv
// Lane addresses and bank-in crossbar selects for the 4-bank, 512-point mixed-radix NTT; outputs registered, start->first beat 2 cycles.
// stall=1 in RUN freezes the group counter and drops addr_valid the next cycle while b*/sel/stage hold.
module ntt_bank_addr_gen #(
    parameter int ADDR_W  = 7,
    parameter int GAP_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              inv,
    input  logic              stall,
    output logic              busy,
    output logic              addr_valid,
    output logic [2:0]        stage,
    output logic              last,
    output logic              done,
    output logic [ADDR_W-1:0] b0,
    output logic [ADDR_W-1:0] b1,
    output logic [ADDR_W-1:0] b2,
    output logic [ADDR_W-1:0] b3,
    output logic [1:0]        sel_a_0,
    output logic [1:0]        sel_a_1,
    output logic [1:0]        sel_a_2,
    output logic [1:0]        sel_a_3
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [6:0]             k_q, k_d;
    logic [2:0]             s_q, s_d;
    logic                   inv_q, inv_d;
    logic [3:0]             gap_q, gap_d;
    logic                   busy_q, busy_d;
    logic                   vld_q, vld_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic [2:0]             stage_q, stage_d;
    logic [3:0][ADDR_W-1:0] b_q, b_d;
    logic [3:0][1:0]        sel_q, sel_d;

    logic [3:0][8:0]        lane_j;
    logic [3:0][1:0]        lane_bank;
    logic [3:0][ADDR_W-1:0] lane_b;
    logic [3:0][1:0]        lane_sel;
    logic [2:0]             final_s;

    // Coefficient index for lane m: radix-4 stages insert m as base-4 digit s of k.
    function automatic logic [8:0] idx_j(input logic [2:0] s, input logic [6:0] k, input logic [1:0] m);
        case (s)
            3'd0:    return {k, m};
            3'd1:    return {k[6:2], m, k[1:0]};
            3'd2:    return {k[6:4], m, k[3:0]};
            3'd3:    return {k[6], m, k[5:0]};
            default: return {m[1], k[5:0], m[0], k[6]};
        endcase
    endfunction

    function automatic logic [1:0] bank_of(input logic [8:0] j);
        return j[1:0] + j[3:2] + j[5:4] + j[7:6] + {1'b0, j[8]};
    endfunction

    assign final_s = inv_q ? 3'd0 : 3'd4;

    // Route each bank to whichever lane lands in it; the map is a permutation by construction.
    always_comb begin
        lane_j    = '0;
        lane_bank = '0;
        lane_b    = '0;
        lane_sel  = '0;
        for (int m = 0; m < 4; m++) begin
            lane_j[m]    = idx_j(s_q, k_q, 2'(m));
            lane_bank[m] = bank_of(lane_j[m]);
            lane_b[m]    = lane_j[m][8:2];
        end
        for (int p = 0; p < 4; p++) begin
            for (int m = 0; m < 4; m++) begin
                if (lane_bank[m] == 2'(p)) lane_sel[p] = 2'(m);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        inv_d   = inv_q;
        gap_d   = gap_q;
        busy_d  = busy_q;
        vld_d   = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        stage_d = stage_q;
        b_d     = b_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (done_q) busy_d = 1'b0;
                if (start && !busy_q) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    inv_d   = inv;
                    s_d     = inv ? 3'd4 : 3'd0;
                    k_d     = 7'd0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    vld_d   = 1'b1;
                    stage_d = s_q;
                    b_d     = lane_b;
                    sel_d   = lane_sel;
                    last_d  = (k_q == 7'd127) && (s_q == final_s);
                    k_d     = k_q + 7'd1;
                    if (k_q == 7'd127) begin
                        if (s_q == final_s) begin
                            state_d = ST_DONE;
                        end else begin
                            s_d     = inv_q ? s_q - 3'd1 : s_q + 3'd1;
                            gap_d   = 4'd0;
                            state_d = (GAP_CYC == 0) ? ST_RUN : ST_GAP;
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == 4'(GAP_CYC - 1)) state_d = ST_RUN;
            end
            default: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            s_q     <= '0;
            inv_q   <= 1'b0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            stage_q <= '0;
            b_q     <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            s_q     <= s_d;
            inv_q   <= inv_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            done_q  <= done_d;
            stage_q <= stage_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
        end
    end

    assign busy       = busy_q;
    assign addr_valid = vld_q;
    assign stage      = stage_q;
    assign last       = last_q;
    assign done       = done_q;
    assign b0         = b_q[0];
    assign b1         = b_q[1];
    assign b2         = b_q[2];
    assign b3         = b_q[3];
    assign sel_a_0    = sel_q[0];
    assign sel_a_1    = sel_q[1];
    assign sel_a_2    = sel_q[2];
    assign sel_a_3    = sel_q[3];

endmodule

// File: tb/tb_ntt_bank_addr_gen.sv
// Directed bench for ntt_bank_addr_gen: beat sequence, crossbar permutation, j coverage, timing, stall and reset.
module tb_ntt_bank_addr_gen;
    logic       clk = 1'b0;
    logic       rst, start, inv, stall;
    logic       busy, addr_valid, last, done;
    logic [2:0] stage;
    logic [6:0] b0, b1, b2, b3;
    logic [1:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3;

    int          checks   = 0;
    int          failures = 0;
    logic [38:0] exp_hold;

    always #5 clk = ~clk;

    ntt_bank_addr_gen #(.ADDR_W(7), .GAP_CYC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .inv(inv), .stall(stall),
        .busy(busy), .addr_valid(addr_valid), .stage(stage), .last(last), .done(done),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .sel_a_0(sel_a_0), .sel_a_1(sel_a_1), .sel_a_2(sel_a_2), .sel_a_3(sel_a_3)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model_j(input int s, input int k, input int m);
        int p4, lo, hi;
        if (s == 4) return 9'(((m >> 1) & 1) * 256 + (k & 63) * 4 + (m & 1) * 2 + ((k >> 6) & 1));
        p4 = 1 << (2 * s);
        lo = k % p4;
        hi = k / p4;
        return 9'(hi * p4 * 4 + m * p4 + lo);
    endfunction

    function automatic int model_bank(input logic [8:0] j);
        int sum, v;
        sum = 0;
        v   = int'(j);
        for (int d = 0; d < 5; d++) begin
            sum += v % 4;
            v    = v / 4;
        end
        return sum % 4;
    endfunction

    // {stage, b0..b3, sel_a_0..3, last}
    function automatic logic [39:0] model_beat(input int s, input int k, input bit is_last);
        logic [6:0] bb [4];
        logic [1:0] ss [4];
        logic [8:0] jv;
        int         base, x;
        for (int m = 0; m < 4; m++) begin
            jv    = model_j(s, k, m);
            bb[m] = jv[8:2];
        end
        base = model_bank(model_j(s, k, 0));
        for (int p = 0; p < 4; p++) begin
            x     = (p - base) & 3;
            ss[p] = (s < 4) ? 2'(x) : 2'(((x & 1) << 1) | (x >> 1));
        end
        return {3'(s), bb[0], bb[1], bb[2], bb[3], ss[0], ss[1], ss[2], ss[3], is_last};
    endfunction

    task automatic run_xform(input bit inv_i, input int stall_pct, input bit do_timing, input bit poke_start);
        logic [39:0] exp_q [$];
        logic [39:0] eb;
        bit          cov [5][512];
        logic [6:0]  lb [4];
        logic [1:0]  ls [4];
        logic [3:0]  mask;
        int          cyc, nbeats, first_cyc, done_cyc, idle, s, cnt;
        bit          done_seen;

        for (int i = 0; i < 5; i++) begin
            s = inv_i ? 4 - i : i;
            for (int k = 0; k < 128; k++) exp_q.push_back(model_beat(s, k, (i == 4) && (k == 127)));
            for (int j = 0; j < 512; j++) cov[i][j] = 1'b0;
        end
        nbeats = 0; first_cyc = -1; done_cyc = -1; idle = 0; done_seen = 1'b0;

        @(posedge clk); #1;
        start = 1'b1; inv = inv_i; stall = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; inv = 1'b0;
        cyc = 1;
        check_val("busy_after_start", {63'd0, busy}, 64'd1);

        while (!done_seen && cyc < 4000) begin
            if (stall && addr_valid) check_val("valid_after_stall", {63'd0, addr_valid}, 64'd0);
            if (addr_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", 64'd1, 64'd0);
                end else begin
                    eb = exp_q.pop_front();
                    check_val($sformatf("beat%0d", nbeats),
                              {stage, b0, b1, b2, b3, sel_a_0, sel_a_1, sel_a_2, sel_a_3, last}, eb);
                    exp_hold = eb[39:1];
                end
                if (!inv_i && nbeats == 0) begin
                    check_val("t2_k0_b", {b0, b1, b2, b3}, {7'd0, 7'd0, 7'd0, 7'd0});
                    check_val("t2_k0_sel", {sel_a_0, sel_a_1, sel_a_2, sel_a_3}, {2'd0, 2'd1, 2'd2, 2'd3});
                end
                if (!inv_i && nbeats == 1) begin
                    check_val("t2_k1_b", {b0, b1, b2, b3}, {7'd1, 7'd1, 7'd1, 7'd1});
                    check_val("t2_k1_sel", {sel_a_0, sel_a_1, sel_a_2, sel_a_3}, {2'd3, 2'd0, 2'd1, 2'd2});
                end
                if ((!inv_i && nbeats == 384) || (inv_i && nbeats == 128)) begin
                    check_val("t3_s3_b", {stage, b0, b1, b2, b3}, {3'd3, 7'd0, 7'd16, 7'd32, 7'd48});
                    check_val("t3_s3_sel", {sel_a_0, sel_a_1, sel_a_2, sel_a_3}, {2'd0, 2'd1, 2'd2, 2'd3});
                end
                if ((!inv_i && nbeats == 512) || (inv_i && nbeats == 0)) begin
                    check_val("t3_s4_b", {stage, b0, b1, b2, b3}, {3'd4, 7'd0, 7'd0, 7'd64, 7'd64});
                    check_val("t3_s4_sel", {sel_a_0, sel_a_1, sel_a_2, sel_a_3}, {2'd0, 2'd2, 2'd1, 2'd3});
                end
                mask = (4'd1 << sel_a_0) | (4'd1 << sel_a_1) | (4'd1 << sel_a_2) | (4'd1 << sel_a_3);
                check_val("banks_distinct", {60'd0, mask}, 64'hf);
                lb = '{b0, b1, b2, b3};
                ls = '{sel_a_0, sel_a_1, sel_a_2, sel_a_3};
                if (stage < 3'd5) begin
                    for (int p = 0; p < 4; p++) begin
                        logic [6:0] a;
                        logic [8:0] jj;
                        int         part;
                        a    = lb[ls[p]];
                        part = model_bank({a, 2'b00});
                        jj   = {a, 2'(p - part)};
                        cov[inv_i ? 4 - int'(stage) : int'(stage)][jj] = 1'b1;
                    end
                end
                if (first_cyc < 0) first_cyc = cyc;
                nbeats++;
            end else begin
                check_val("hold_when_idle",
                          {stage, b0, b1, b2, b3, sel_a_0, sel_a_1, sel_a_2, sel_a_3}, exp_hold);
                if (busy && nbeats > 0 && !done) idle++;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check_val("busy_at_done", {63'd0, busy}, 64'd1);
            end
            stall = ($urandom_range(0, 99) < stall_pct);
            start = poke_start && (cyc == 100);
            inv   = start ? ~inv_i : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        stall = 1'b0;
        start = 1'b0;

        if (!done_seen) check_val("done_timeout", 64'd0, 64'd1);
        check_val("beat_count", 64'(nbeats), 64'd640);
        check_val("busy_after_done", {62'd0, busy, done}, 64'd0);
        if (do_timing) begin
            check_val("first_beat_cycle", 64'(first_cyc), 64'd2);
            check_val("done_cycle", 64'(done_cyc), 64'd658);
            check_val("gap_idle_cycles", 64'(idle), 64'd16);
        end
        for (int i = 0; i < 5; i++) begin
            cnt = 0;
            for (int j = 0; j < 512; j++) cnt += int'(cov[i][j]);
            check_val($sformatf("j_cover_pos%0d", i), 64'(cnt), 64'd512);
        end
    endtask

    task automatic reset_mid_run();
        @(posedge clk); #1;
        start = 1'b1; inv = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_val("t1_async_clear",
                  {busy, addr_valid, stage, last, done, b0, b1, b2, b3, sel_a_0, sel_a_1, sel_a_2, sel_a_3}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check_val("t1_no_done", {62'd0, done, busy}, 64'd0);
        end
        rst      = 1'b0;
        exp_hold = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inv = 1'b0; stall = 1'b0;
        exp_hold = '0;
        #12;
        check_val("reset_state",
                  {busy, addr_valid, stage, last, done, b0, b1, b2, b3, sel_a_0, sel_a_1, sel_a_2, sel_a_3}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_xform(1'b0, 0, 1'b1, 1'b0);
        run_xform(1'b0, 30, 1'b0, 1'b1);
        reset_mid_run();
        run_xform(1'b1, 0, 1'b1, 1'b0);
        run_xform(1'b1, 30, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
